// File: rtl/instr_decode_queue.sv
// -----------------------------------------------------------------------------
// instr_decode_queue
//
// Purpose:
//   Decodes a 32-bit RISC-V instruction word into its raw field slices, a
//   format class and a sign-extended immediate. The decoded result and the PC
//   are stored in a DEPTH-entry FIFO that sits between fetch and the
//   register-read/execute stage. Both sides use a valid/ready handshake.
//
// Parameters:
//   XLEN   data/PC width (32 or 64); immediates are sign-extended to XLEN
//   DEPTH  number of decoded-entry slots (power of two, >= 2)
//   CNT_W  width of the occupancy count
//
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous reset, active-high
//   in_valid       instruction and PC valid
//   in_ready       queue can accept (count < DEPTH)
//   in_instr       raw instruction word
//   in_pc          instruction address
//   flush          synchronous queue clear, wins over push and pop
//   out_valid      head entry valid (count != 0)
//   out_ready      consumer takes the head entry
//   out_opcode     instr[6:0]
//   out_rd         instr[11:7]
//   out_funct3     instr[14:12]
//   out_rs1        instr[19:15]
//   out_rs2        instr[24:20]
//   out_funct7     instr[31:25]
//   out_imm        decoded immediate
//   out_fmt        R=0, I=1, S=2, B=3, U=4, J=5, ILL=7
//   out_pc         PC of the head entry
//   count          current occupancy
//   perf_accepted  (DECODE_PERF_EN only) pushes accepted, wraps at 2^32
//   perf_illegal   (DECODE_PERF_EN only) accepted pushes decoded as ILL
//
// Optional feature macro: DECODE_PERF_EN adds the two performance counters.
// All out_* data outputs read 0 while the queue is empty.
// -----------------------------------------------------------------------------
module instr_decode_queue #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [XLEN-1:0]  in_pc,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [6:0]       out_opcode,
    output logic [4:0]       out_rd,
    output logic [2:0]       out_funct3,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [6:0]       out_funct7,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic [XLEN-1:0]  out_pc,
`ifdef DECODE_PERF_EN
    output logic [31:0]      perf_accepted,
    output logic [31:0]      perf_illegal,
`endif
    output logic [CNT_W-1:0] count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] DepthCnt = CNT_W'(DEPTH);

    // Format class encodings
    localparam logic [2:0] FmtR   = 3'd0;
    localparam logic [2:0] FmtI   = 3'd1;
    localparam logic [2:0] FmtS   = 3'd2;
    localparam logic [2:0] FmtB   = 3'd3;
    localparam logic [2:0] FmtU   = 3'd4;
    localparam logic [2:0] FmtJ   = 3'd5;
    localparam logic [2:0] FmtIll = 3'd7;

    // -------------------------------------------------------------------------
    // Combinational decode of the incoming word
    // -------------------------------------------------------------------------
    logic [2:0]      w_fmt;
    logic [31:0]     w_imm32;
    logic [XLEN-1:0] w_imm;
    logic [31:0]     w_fields;

    always_comb begin
        w_fmt = FmtIll;
        // Compressed / non-32-bit encodings are illegal here.
        if (in_instr[1:0] == 2'b11) begin
            case (in_instr[6:0])
                7'b0110011: w_fmt = FmtR;
                7'b0010011,
                7'b0000011,
                7'b1100111,
                7'b1110011: w_fmt = FmtI;
                7'b0100011: w_fmt = FmtS;
                7'b1100011: w_fmt = FmtB;
                7'b0110111,
                7'b0010111: w_fmt = FmtU;
                7'b1101111: w_fmt = FmtJ;
                default:    w_fmt = FmtIll;
            endcase
        end
    end

    always_comb begin
        w_imm32 = 32'd0;
        case (w_fmt)
            FmtI: w_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
            FmtS: w_imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            FmtB: w_imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                             in_instr[30:25], in_instr[11:8], 1'b0};
            FmtU: w_imm32 = {in_instr[31:12], 12'd0};
            FmtJ: w_imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                             in_instr[20], in_instr[30:21], 1'b0};
            default: w_imm32 = 32'd0;
        endcase
    end

    // Sized cast of a signed value sign-extends when XLEN is 64.
    assign w_imm = XLEN'($signed(w_imm32));

    // The six field slices together cover every bit of the word.
    assign w_fields = {in_instr[31:25], in_instr[24:20], in_instr[19:15],
                       in_instr[14:12], in_instr[11:7], in_instr[6:0]};

    // -------------------------------------------------------------------------
    // FIFO control
    // -------------------------------------------------------------------------
    logic [PtrW-1:0]  r_wr_ptr;
    logic [PtrW-1:0]  r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [PtrW-1:0]  w_wr_ptr_nxt;
    logic [PtrW-1:0]  w_rd_ptr_nxt;
    logic [CNT_W-1:0] w_count_nxt;
    logic             w_push;
    logic             w_pop;
    logic             w_push_en;

    assign in_ready  = (r_count < DepthCnt);
    assign out_valid = (r_count != '0);
    assign count     = r_count;

    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;
    // Flush discards any concurrent push, so it never reaches storage.
    assign w_push_en = w_push & ~flush;

    always_comb begin
        w_wr_ptr_nxt = r_wr_ptr;
        w_rd_ptr_nxt = r_rd_ptr;
        w_count_nxt  = r_count;
        if (flush) begin
            w_wr_ptr_nxt = '0;
            w_rd_ptr_nxt = '0;
            w_count_nxt  = '0;
        end else begin
            if (w_push) begin
                w_wr_ptr_nxt = r_wr_ptr + PtrW'(1);
            end
            if (w_pop) begin
                w_rd_ptr_nxt = r_rd_ptr + PtrW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   w_count_nxt = r_count + CNT_W'(1);
                2'b01:   w_count_nxt = r_count - CNT_W'(1);
                default: w_count_nxt = r_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= w_wr_ptr_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
            r_count  <= w_count_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Entry storage (no reset; contents are masked while empty)
    // -------------------------------------------------------------------------
    logic [31:0]     r_field_mem [DEPTH];
    logic [XLEN-1:0] r_imm_mem   [DEPTH];
    logic [XLEN-1:0] r_pc_mem    [DEPTH];
    logic [2:0]      r_fmt_mem   [DEPTH];

    always_ff @(posedge clk) begin
        if (w_push_en) begin
            r_field_mem[r_wr_ptr] <= w_fields;
            r_imm_mem[r_wr_ptr]   <= w_imm;
            r_pc_mem[r_wr_ptr]    <= in_pc;
            r_fmt_mem[r_wr_ptr]   <= w_fmt;
        end
    end

    // -------------------------------------------------------------------------
    // Head entry outputs
    // -------------------------------------------------------------------------
    logic [31:0] w_head_fields;

    always_comb begin
        w_head_fields = '0;
        out_imm       = '0;
        out_pc        = '0;
        out_fmt       = '0;
        if (out_valid) begin
            w_head_fields = r_field_mem[r_rd_ptr];
            out_imm       = r_imm_mem[r_rd_ptr];
            out_pc        = r_pc_mem[r_rd_ptr];
            out_fmt       = r_fmt_mem[r_rd_ptr];
        end
    end

    assign out_opcode = w_head_fields[6:0];
    assign out_rd     = w_head_fields[11:7];
    assign out_funct3 = w_head_fields[14:12];
    assign out_rs1    = w_head_fields[19:15];
    assign out_rs2    = w_head_fields[24:20];
    assign out_funct7 = w_head_fields[31:25];

`ifdef DECODE_PERF_EN
    // -------------------------------------------------------------------------
    // Performance counters: survive flush, cleared only by rst
    // -------------------------------------------------------------------------
    logic [31:0] r_perf_accepted;
    logic [31:0] r_perf_illegal;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_accepted <= '0;
            r_perf_illegal  <= '0;
        end else if (w_push_en) begin
            r_perf_accepted <= r_perf_accepted + 32'd1;
            if (w_fmt == FmtIll) begin
                r_perf_illegal <= r_perf_illegal + 32'd1;
            end
        end
    end

    assign perf_accepted = r_perf_accepted;
    assign perf_illegal  = r_perf_illegal;
`endif

endmodule

// File: tb/tb_instr_decode_queue.sv
// -----------------------------------------------------------------------------
// tb_instr_decode_queue
//
// Directed bench for instr_decode_queue (XLEN=32, DEPTH=4). Inputs change on
// the falling edge; outputs are compared on the falling edge before the next
// inputs are driven. Define DECODE_PERF_EN to cover the performance counters.
// -----------------------------------------------------------------------------
module tb_instr_decode_queue;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic [XLEN-1:0]  in_pc;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [6:0]       out_opcode;
    logic [4:0]       out_rd;
    logic [2:0]       out_funct3;
    logic [4:0]       out_rs1;
    logic [4:0]       out_rs2;
    logic [6:0]       out_funct7;
    logic [XLEN-1:0]  out_imm;
    logic [2:0]       out_fmt;
    logic [XLEN-1:0]  out_pc;
    logic [CNT_W-1:0] count;
`ifdef DECODE_PERF_EN
    logic [31:0]      perf_accepted;
    logic [31:0]      perf_illegal;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    instr_decode_queue #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_instr      (in_instr),
        .in_pc         (in_pc),
        .flush         (flush),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_opcode    (out_opcode),
        .out_rd        (out_rd),
        .out_funct3    (out_funct3),
        .out_rs1       (out_rs1),
        .out_rs2       (out_rs2),
        .out_funct7    (out_funct7),
        .out_imm       (out_imm),
        .out_fmt       (out_fmt),
        .out_pc        (out_pc),
`ifdef DECODE_PERF_EN
        .perf_accepted (perf_accepted),
        .perf_illegal  (perf_illegal),
`endif
        .count         (count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] pc);
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
        step();
    endtask

    function automatic logic [31:0] addi(input int imm);
        return {imm[11:0], 5'd0, 3'd0, 5'd1, 7'h13};
    endfunction

    initial begin
        logic [31:0] sb_imm[$];
        logic [31:0] sb_pc[$];
        int          sent;
        int          got;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_instr  = '0;
        in_pc     = '0;
        flush     = 1'b0;
        out_ready = 1'b0;

        // Reset state
        #12;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_imm", 64'(out_imm), 64'd0);
        chk("rst_out_pc", 64'(out_pc), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Illegal encodings: all-zero word and bad low bits
        drive(32'h0000_0000, 32'h10);
        drive(32'h0050_0091, 32'h14);
        in_valid = 1'b0;
        chk("ill0_valid", 64'(out_valid), 64'd1);
        chk("ill0_fmt", 64'(out_fmt), 64'd7);
        chk("ill0_imm", 64'(out_imm), 64'd0);
        chk("ill0_pc", 64'(out_pc), 64'h10);
        chk("ill_count", 64'(count), 64'd2);
        out_ready = 1'b1;
        step();
        chk("ill1_fmt", 64'(out_fmt), 64'd7);
        chk("ill1_imm", 64'(out_imm), 64'd0);
        chk("ill1_opcode", 64'(out_opcode), 64'h11);
        chk("ill1_rd", 64'(out_rd), 64'd1);
        step();
        chk("ill_drained", 64'(count), 64'd0);
`ifdef DECODE_PERF_EN
        chk("perf_acc_ill", 64'(perf_accepted), 64'd2);
        chk("perf_ill_ill", 64'(perf_illegal), 64'd2);
`endif

        // addi x1,x0,5 with out_ready high
        drive(32'h0050_0093, 32'h100);
        in_valid = 1'b0;
        chk("addi_valid", 64'(out_valid), 64'd1);
        chk("addi_opcode", 64'(out_opcode), 64'h13);
        chk("addi_rd", 64'(out_rd), 64'd1);
        chk("addi_rs1", 64'(out_rs1), 64'd0);
        chk("addi_funct3", 64'(out_funct3), 64'd0);
        chk("addi_imm", 64'(out_imm), 64'h5);
        chk("addi_fmt", 64'(out_fmt), 64'd1);
        chk("addi_pc", 64'(out_pc), 64'h100);
        step();
        chk("addi_popped", 64'(count), 64'd0);
        chk("empty_opcode", 64'(out_opcode), 64'd0);

        // beq x0,x0,-4 then lui x2,0x12345
        out_ready = 1'b0;
        drive(32'hFE00_0EE3, 32'h104);
        drive(32'h1234_5137, 32'h108);
        in_valid = 1'b0;
        chk("beq_count", 64'(count), 64'd2);
        chk("beq_fmt", 64'(out_fmt), 64'd3);
        chk("beq_imm", 64'(out_imm), 64'hFFFF_FFFC);
        chk("beq_funct7", 64'(out_funct7), 64'h7F);
        out_ready = 1'b1;
        step();
        chk("lui_fmt", 64'(out_fmt), 64'd4);
        chk("lui_rd", 64'(out_rd), 64'd2);
        chk("lui_imm", 64'(out_imm), 64'h1234_5000);
        chk("lui_count", 64'(count), 64'd1);
        step();
        chk("lui_drained", 64'(count), 64'd0);

        // Fill to DEPTH, hold a fifth request, then drain in order
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) drive(addi(i + 1), 32'h200 + 32'(4 * i));
        chk("full_count", 64'(count), 64'd4);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        chk("full_head", 64'(out_imm), 64'd1);
        in_instr = addi(9);
        in_pc    = 32'h300;
        step();
        chk("held_count", 64'(count), 64'd4);
        chk("held_head_pc", 64'(out_pc), 64'h200);
        out_ready = 1'b1;
        step();
        chk("pop1_count", 64'(count), 64'd3);
        chk("pop1_in_ready", 64'(in_ready), 64'd1);
        chk("pop1_head", 64'(out_imm), 64'd2);
        step();
        in_valid = 1'b0;
        chk("pushpop_count", 64'(count), 64'd3);
        chk("pushpop_head", 64'(out_imm), 64'd3);
        step();
        chk("drain_head4", 64'(out_imm), 64'd4);
        step();
        chk("drain_head9", 64'(out_imm), 64'd9);
        chk("drain_pc9", 64'(out_pc), 64'h300);
        step();
        chk("drain_empty", 64'(out_valid), 64'd0);

        // Flush a full queue with a concurrent push
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) drive(addi(i + 16), 32'h500 + 32'(4 * i));
        in_instr = addi(7);
        in_pc    = 32'h600;
        flush    = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_in_ready", 64'(in_ready), 64'd1);
        chk("flush_out_pc", 64'(out_pc), 64'd0);
`ifdef DECODE_PERF_EN
        chk("perf_acc_flush", 64'(perf_accepted), 64'd14);
        chk("perf_ill_flush", 64'(perf_illegal), 64'd2);
`endif
        step();
        chk("flush_no_store", 64'(count), 64'd0);

        // Asynchronous reset with three entries queued
        for (int i = 0; i < 3; i++) drive(addi(i + 32), 32'h700 + 32'(4 * i));
        in_valid = 1'b0;
        chk("prerst_count", 64'(count), 64'd3);
        #2 rst = 1'b1;
        #1;
        chk("arst_count", 64'(count), 64'd0);
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_in_ready", 64'(in_ready), 64'd1);
`ifdef DECODE_PERF_EN
        chk("arst_perf_acc", 64'(perf_accepted), 64'd0);
`endif
        #1 rst = 1'b0;
        @(negedge clk);

        // Ten entries across pointer wrap with out_ready toggling
        sent = 0;
        got  = 0;
        for (int cyc = 0; cyc < 80 && got < 10; cyc++) begin
            out_ready = ((cyc % 3) != 0);
            in_valid  = (sent < 10);
            in_instr  = addi(64 + sent);
            in_pc     = 32'h800 + 32'(4 * sent);
            #1;
            if (out_valid && out_ready) begin
                chk("wrap_imm", 64'(out_imm), 64'(sb_imm.pop_front()));
                chk("wrap_pc", 64'(out_pc), 64'(sb_pc.pop_front()));
                got++;
            end
            if (in_valid && in_ready) begin
                sb_imm.push_back(32'(64 + sent));
                sb_pc.push_back(32'h800 + 32'(4 * sent));
                sent++;
            end
            step();
        end
        in_valid = 1'b0;
        chk("wrap_received", 64'(got), 64'd10);
        chk("wrap_final_count", 64'(count), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/instr_decode_queue.md
Name: instr_decode_queue

Overview:
- Parametrised successor to the combinational RISC-V field parser.
- Accepts 32-bit instructions plus PC over a valid/ready handshake and decodes them: fields, format class, and sign-extended immediate.
- Stores decoded entries in a DEPTH-entry FIFO.
- Sits between fetch and register-read/execute, decoupling fetch stalls from the back end.

Parameters:
- XLEN, 32, data/PC width; immediates are sign-extended to XLEN. Legal values: 32 or 64.
- DEPTH, 4, number of decoded-entry slots. Power of two, ≥2.
- CNT_W, $clog2(DEPTH)+1, width of the occupancy count.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-high
- in_valid  in  1  instruction and PC valid
- in_ready  out  1  queue can accept
- in_instr  in  32  raw instruction
- in_pc  in  XLEN  instruction address
- flush  in  1  synchronous queue clear
- out_valid  out  1  head entry valid
- out_ready  in  1  consumer takes head
- out_opcode  out  7  instr[6:0]
- out_rd  out  5  instr[11:7]
- out_funct3  out  3  instr[14:12]
- out_rs1  out  5  instr[19:15]
- out_rs2  out  5  instr[24:20]
- out_funct7  out  7  instr[31:25]
- out_imm  out  XLEN  decoded immediate
- out_fmt  out  3  format: R=0, I=1, S=2, B=3, U=4, J=5, ILL=7
- out_pc  out  XLEN  PC of head entry
- count  out  CNT_W  current occupancy

Behaviour:
- Reset (asynchronous, rst=1):
  - Read and write pointers and count go to 0.
  - out_valid=0, in_ready=1.
  - Out_* data outputs read 0 while empty.
  - Reset asserted mid-transfer discards all entries immediately.
- Decode: combinational on in_instr. The decoded result is written into the FIFO, not the raw word.
- Format by opcode:
  - 0110011 → R
  - 0010011, 0000011, 1100111, 1110011 → I
  - 0100011 → S
  - 1100011 → B
  - 0110111, 0010111 → U
  - 1101111 → J
  - Any other opcode, or instr[1:0]≠2'b11 → ILL
- Immediate (sign bit is instr[31], extended to XLEN):
  - I: instr[31:20]
  - S: {instr[31:25], instr[11:7]}
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}
  - U: {instr[31:12], 12'b0}
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}
  - R and ILL: 0
- Field outputs are always the raw bit slices listed in Ports, regardless of format.
- Handshake:
  - in_ready = (count<DEPTH). Push when in_valid & in_ready.
  - out_valid = (count≠0). Pop when out_valid & out_ready.
  - Producer holds in_* stable while in_valid & !in_ready. Queue holds out_* stable while out_valid & !out_ready.
- Latency: an entry pushed at edge N is visible on out_* with out_valid=1 after edge N. There is no same-cycle bypass.
- Simultaneous push and pop: count is unchanged and both pointers advance. When full, in_ready=0, so no push occurs even if a pop happens in the same cycle.
- Empty: pop is impossible because out_valid=0. Out_* read 0.
- Pointer wrap: log2(DEPTH) bits, natural wrap from DEPTH-1 to 0.
- flush=1 at an edge:
  - count, rd_ptr and wr_ptr go to 0.
  - Any concurrent push or pop is ignored.
  - in_ready=1 next cycle.
- Storage: registered array, no reset required on data. Out_* are masked to 0 when empty.

Optional Feature:
- Macro: DECODE_PERF_EN.
- Defined:
  - Adds output ports perf_accepted[31:0] and perf_illegal[31:0].
  - perf_accepted increments on every push.
  - perf_illegal increments on every push whose decoded format is ILL.
  - Both wrap at 2^32 and reset to 0 on rst.
  - Both are unaffected by flush.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Push 0x00500093 (addi x1,x0,5), pc=0x100, out_ready=1 → next cycle: out_valid=1, opcode=0x13, rd=1, rs1=0, funct3=0, imm=0x00000005, fmt=1, pc=0x100. Following cycle: count=0.
- Push 0xFE000EE3 (beq x0,x0,-4) → imm=0xFFFFFFFC, fmt=3. Push 0x12345137 (lui x2) → rd=2, imm=0x12345000, fmt=4.
- DEPTH=4, out_ready=0, push 4 instructions → count=4, in_ready=0. A 5th in_valid is held, not lost. Raise out_ready → entries drain in push order, in_ready=1 after the first pop.
- Full queue, flush=1 with concurrent in_valid=1 → next cycle: count=0, out_valid=0, in_ready=1, and the concurrent instruction is not stored.
- Push 0x00000000 → fmt=7, imm=0. With DECODE_PERF_EN defined: perf_illegal=1, perf_accepted=1.
- Push 3 entries, assert rst asynchronously mid-cycle → immediately count=0, out_valid=0. 10 pushes and pops across wrap with out_ready toggling → output order matches input order.
